debounce_bank: RTL and testbench

Per-button input conditioner for the Tetris board buttons. Each raw push-button input gets a 2-flop synchronizer and a saturating-count debouncer. The block drives clean, glitch-free levels to the downstream rising-edge pulse generators, one per button. An optional hold-to-repeat (DAS) feature inserts one-cycle low gaps into a held level, so the downstream edge detector emits repeat pulses.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_cell.sv | 126 ++++++++++++
 rtl/debounce_bank.sv | 30 +++
 tb/tb_debounce_bank.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types, default 100 MHz timing and width helpers for the button debounce bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  localparam int DEF_N               = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 30_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

  // Counter width able to hold 0..max_val-1; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-button conditioner: 2-flop synchronizer, saturating debounce counter and,
// with DEBOUNCE_BANK_REPEAT_EN defined, a hold-to-repeat gap generator.
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_db
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (REPEAT_DELAY >= 2) && (REPEAT_PERIOD >= 2);

  if (!CFG_OK) begin : g_bad_cfg
    $error("debounce_cell: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 2");
  end

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // Any return of sync2 to the accepted level restarts the count from zero.
  always_comb begin
    sync1_d  = pb_in;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int HW = cnt_w(max_i(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  rep_state_t    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          gap;
  logic          pb_db_q, pb_db_d;

  // Release (stable_d low) overrides everything, including a gap due this cycle.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gap     = 1'b0;
    if (!stable_d) begin
      state_d = IDLE;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DELAY;
          hcnt_d  = '0;
        end
        DELAY: begin
          if (hcnt_q == DELAY_LAST) begin
            gap     = 1'b1;
            state_d = REPEAT;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        REPEAT: begin
          if (hcnt_q == PERIOD_LAST) begin
            gap    = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
        end
      endcase
    end
    pb_db_d = stable_d & ~gap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      pb_db_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      pb_db_q <= pb_db_d;
    end
  end

  assign pb_db = pb_db_q;
`else
  assign pb_db = stable_q;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of N independent button conditioners feeding the edge detectors.
// Hold-to-repeat gaps are enabled by defining DEBOUNCE_BANK_REPEAT_EN.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N               = DEF_N,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pb_in,
  output logic [N-1:0] pb_db
);

  for (genvar i = 0; i < N; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .pb_in(pb_in[i]),
      .pb_db(pb_db[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed and random button traffic against a window-based
// reference model; the expected level for every clock edge is queued and checked.
module tb_debounce_bank;

  localparam int N    = 2;
  localparam int D    = 4;
  localparam int RD   = 6;
  localparam int RP   = 3;
  localparam int HMAX = 4096;

  logic         clk;
  logic         rst;
  logic [N-1:0] pb_in;
  logic [N-1:0] pb_db;

  debounce_bank #(
    .N              (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pb_in(pb_in),
    .pb_db(pb_db)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    model_on = 1'b1;
  string phase    = "reset";

  logic [N-1:0] exp_q[$];
  int           cyc_q[$];

  // ---------------- reference model ----------------
  // A level is accepted at edge t when the input sampled at edges t-D-1..t-2 all
  // differ from the accepted level and no reset occurred at edges t-D-1..t.
  logic [N-1:0] s_hist[HMAX];
  bit           r_hist[HMAX];
  bit           m_stable[N];
  int           m_press[N];

  always @(posedge clk) begin
    if (model_on) begin
      logic [N-1:0] e;
      int t;
      t = cyc;
      if (t >= HMAX) begin
        $display("FAIL cycle_budget got=%0d limit=%0d", t, HMAX);
        $fatal(1, "cycle budget exceeded");
      end
      s_hist[t] = pb_in;
      r_hist[t] = rst;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          m_stable[i] = 1'b0;
          m_press[i]  = -1;
        end else if (t >= D + 1) begin
          bit ok;
          ok = 1'b1;
          for (int k = t - D - 1; k <= t - 2; k++)
            if (s_hist[k][i] == m_stable[i]) ok = 1'b0;
          for (int k = t - D - 1; k <= t; k++)
            if (r_hist[k]) ok = 1'b0;
          if (ok) begin
            m_stable[i] = ~m_stable[i];
            if (m_stable[i]) m_press[i] = t;
          end
        end
        e[i] = m_stable[i];
`ifdef DEBOUNCE_BANK_REPEAT_EN
        if (m_stable[i] && (t >= m_press[i] + RD) && (((t - m_press[i] - RD) % RP) == 0))
          e[i] = 1'b0;
`endif
      end
      exp_q.push_back(e);
      cyc_q.push_back(t);
      cyc = cyc + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [N-1:0] e;
      int t;
      e = exp_q.pop_front();
      t = cyc_q.pop_front();
      n_checks++;
      if (pb_db !== e) begin
        n_fail++;
        $display("FAIL pb_db phase=%s edge=%0d got=%b expected=%b", phase, t, pb_db, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic apply(input logic [N-1:0] v, input logic r, input int n);
    pb_in = v;
    rst   = r;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] v;
    logic         r;
    pb_in = '0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);

    phase = "clean_press";
    apply(2'b00, 1'b0, 6);
    apply(2'b01, 1'b0, 14);

    phase = "release";
    apply(2'b00, 1'b0, 10);

    phase = "glitches";
    apply(2'b01, 1'b0, 3);
    apply(2'b00, 1'b0, 1);
    apply(2'b01, 1'b0, 3);
    apply(2'b00, 1'b0, 8);
    phase = "min_width";
    apply(2'b01, 1'b0, 4);
    apply(2'b00, 1'b0, 12);

    phase = "hold_bounce";
    apply(2'b01, 1'b0, 12);
    apply(2'b00, 1'b0, 2);
    apply(2'b01, 1'b0, 10);
    apply(2'b00, 1'b0, 10);

    phase = "indep_reset";
    apply(2'b01, 1'b0, 2);
    apply(2'b11, 1'b0, 3);
    apply(2'b11, 1'b1, 1);
    apply(2'b11, 1'b0, 12);
    apply(2'b00, 1'b0, 10);

    phase = "long_hold";
    apply(2'b01, 1'b0, 22);
    apply(2'b00, 1'b0, 10);
    phase = "release_mid_repeat";
    apply(2'b11, 1'b0, 13);
    apply(2'b00, 1'b0, 10);

    phase = "random";
    v = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) v = N'($urandom_range(0, (1 << N) - 1));
      r = ($urandom_range(0, 49) == 0);
      apply(v, r, 1);
    end

    phase = "drain";
    apply(2'b00, 1'b0, 12);
    model_on = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
